// File: rtl/fetch_redirect_unit_pkg.sv
// Core-wide fetch constants: PC-source encoding,
// reset vector and the bubble instruction.
package fetch_redirect_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;
endpackage

// File: rtl/fetch_redirect_unit_if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall > load.
// Flush and reset both leave a NOP bubble with zeroed PCs.
module if_id_reg
  import fetch_redirect_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pcplus4,
  output logic [31:0]     instr_q,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pcplus4_q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
    end else if (!stall) begin
      instr_q   <= instr;
      pc_q      <= pc;
      pcplus4_q <= pcplus4;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC register, next-PC select, redirect flushes,
// misalignment flags and saturating redirect counter.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int XLEN = fetch_redirect_unit_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR =
    fetch_redirect_unit_pkg::RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR =
    fetch_redirect_unit_pkg::NOP_INSTR,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushEHaz,
  input  logic [1:0]       PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [XLEN-1:0]  ALUResultE,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MisalignE,
  output logic             MisalignSticky,
  output logic             IllegalSrcE,
  output logic [CNT_W-1:0] RedirectCount
);

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pcplus4f;

  assign pcplus4f = PCF + XLEN'(4);

  always_comb begin
    redirect = 1'b0;
    target   = PCTargetE;
    unique case (PCSrcE)
      PCSRC_BR: redirect = 1'b1;
      PCSRC_JALR: begin
        redirect = 1'b1;
        target   = {ALUResultE[XLEN-1:1], 1'b0};
      end
      default: redirect = 1'b0;
    endcase
  end

  assign IllegalSrcE = (PCSrcE == 2'b11);
  assign FlushD      = redirect;
  assign FlushE      = redirect | FlushEHaz;
  assign MisalignE   = redirect & (target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_VECTOR;
    end else if (redirect) begin
      PCF <= target;
    end else if (!StallF) begin
      PCF <= pcplus4f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MisalignSticky <= 1'b0;
      RedirectCount  <= '0;
    end else begin
      if (MisalignE) MisalignSticky <= 1'b1;
      if (redirect && RedirectCount != '1)
        RedirectCount <= RedirectCount + CNT_W'(1);
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .flush     (FlushD),
    .stall     (StallD),
    .instr     (InstrF),
    .pc        (PCF),
    .pcplus4   (pcplus4f),
    .instr_q   (InstrD),
    .pc_q      (PCD),
    .pcplus4_q (PCPlus4D)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit (4-bit counter
// build so saturation is reachable).
module tb_fetch_redirect_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushEHaz;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        FlushD, FlushE, MisalignE;
  logic        MisalignSticky, IllegalSrcE;
  logic [3:0]  RedirectCount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Simple instruction memory: data tagged with its address.
  assign InstrF = {16'hC0DE, PCF[15:0]};

  fetch_redirect_unit #(.CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushEHaz      (FlushEHaz),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .ALUResultE     (ALUResultE),
    .InstrF         (InstrF),
    .PCF            (PCF),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .MisalignE      (MisalignE),
    .MisalignSticky (MisalignSticky),
    .IllegalSrcE    (IllegalSrcE),
    .RedirectCount  (RedirectCount)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    StallF = 1'b0;
    StallD = 1'b0;
    FlushEHaz = 1'b0;
    PCSrcE = 2'b00;
    PCTargetE = '0;
    ALUResultE = '0;
    tick();
    tick();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instrd", InstrD, NOP);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4d", PCPlus4D, 32'h0);
    chk("rst_cnt", RedirectCount, 32'd0);
    chk("rst_sticky", MisalignSticky, 32'd0);

    reset = 1'b0;
    #1;
    chk("seq_flushd", FlushD, 32'd0);
    chk("seq_flushe", FlushE, 32'd0);
    tick();
    chk("seq_pcf4", PCF, 32'h4);
    chk("seq_instrd0", InstrD, 32'hC0DE_0000);
    chk("seq_pc4d0", PCPlus4D, 32'h4);
    tick();
    chk("seq_pcf8", PCF, 32'h8);
    chk("seq_instrd4", InstrD, 32'hC0DE_0004);
    chk("seq_pcd4", PCD, 32'h4);
    tick();
    chk("seq_pcf12", PCF, 32'hC);
    chk("seq_cnt", RedirectCount, 32'd0);

    for (int i = 0; i < 5; i++) tick();
    chk("pre_br_pcf", PCF, 32'h20);
    PCSrcE = 2'b01;
    PCTargetE = 32'h100;
    #1;
    chk("br_flushd", FlushD, 32'd1);
    chk("br_flushe", FlushE, 32'd1);
    chk("br_misal", MisalignE, 32'd0);
    tick();
    PCSrcE = 2'b00;
    chk("br_pcf", PCF, 32'h100);
    chk("br_instrd", InstrD, NOP);
    chk("br_pcd", PCD, 32'h0);
    chk("br_pc4d", PCPlus4D, 32'h0);
    chk("br_cnt", RedirectCount, 32'd1);

    FlushEHaz = 1'b1;
    #1;
    chk("haz_flushe", FlushE, 32'd1);
    chk("haz_flushd", FlushD, 32'd0);
    FlushEHaz = 1'b0;

    PCSrcE = 2'b10;
    ALUResultE = 32'h205;
    #1;
    chk("jalr_misal0", MisalignE, 32'd0);
    tick();
    chk("jalr_pcf", PCF, 32'h204);
    chk("jalr_cnt", RedirectCount, 32'd2);
    chk("jalr_sticky0", MisalignSticky, 32'd0);
    ALUResultE = 32'h206;
    #1;
    chk("jalr_misal1", MisalignE, 32'd1);
    tick();
    PCSrcE = 2'b00;
    chk("jalr_pcf_mis", PCF, 32'h206);
    chk("jalr_sticky1", MisalignSticky, 32'd1);
    chk("jalr_cnt3", RedirectCount, 32'd3);
    tick();
    chk("seq_after_mis", PCF, 32'h20A);
    chk("sticky_hold", MisalignSticky, 32'd1);

    PCSrcE = 2'b01;
    PCTargetE = 32'h3C;
    tick();
    PCSrcE = 2'b00;
    tick();
    chk("stall_pre_pcf", PCF, 32'h40);
    StallF = 1'b1;
    StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pcf", PCF, 32'h40);
      chk("stall_instrd", InstrD, 32'hC0DE_003C);
      chk("stall_pcd", PCD, 32'h3C);
      chk("stall_pc4d", PCPlus4D, 32'h40);
    end
    PCSrcE = 2'b01;
    PCTargetE = 32'h80;
    tick();
    PCSrcE = 2'b00;
    StallF = 1'b0;
    StallD = 1'b0;
    chk("stallbr_pcf", PCF, 32'h80);
    chk("stallbr_instrd", InstrD, NOP);
    chk("stallbr_pcd", PCD, 32'h0);
    chk("stallbr_cnt", RedirectCount, 32'd5);

    PCSrcE = 2'b01;
    PCTargetE = 32'h10;
    tick();
    chk("ill_pre_pcf", PCF, 32'h10);
    PCSrcE = 2'b11;
    PCTargetE = 32'h103;
    ALUResultE = 32'h302;
    #1;
    chk("ill_flag", IllegalSrcE, 32'd1);
    chk("ill_flushd", FlushD, 32'd0);
    chk("ill_flushe", FlushE, 32'd0);
    chk("ill_misal", MisalignE, 32'd0);
    tick();
    PCSrcE = 2'b00;
    #1;
    chk("ill_pcf", PCF, 32'h14);
    chk("ill_cnt", RedirectCount, 32'd6);
    chk("ill_instrd", InstrD, 32'hC0DE_0010);
    chk("ill_clear", IllegalSrcE, 32'd0);

    PCSrcE = 2'b01;
    PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 2'b00;
    chk("wrap_pre", PCF, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pcf", PCF, 32'h0);
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pc4d", PCPlus4D, 32'h0);
    chk("wrap_instrd", InstrD, 32'hC0DE_FFFC);

    PCSrcE = 2'b01;
    PCTargetE = 32'h200;
    for (int i = 0; i < 8; i++) tick();
    chk("sat_reach", RedirectCount, 32'd15);
    tick();
    tick();
    chk("sat_hold", RedirectCount, 32'd15);

    PCTargetE = 32'h300;
    reset = 1'b1;
    tick();
    chk("rstbr_pcf", PCF, 32'h0);
    chk("rstbr_cnt", RedirectCount, 32'd0);
    chk("rstbr_instrd", InstrD, NOP);
    chk("rstbr_pcd", PCD, 32'h0);
    chk("rstbr_sticky", MisalignSticky, 32'd0);
    reset = 1'b0;
    PCSrcE = 2'b00;
    tick();
    chk("post_rst_pcf", PCF, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
